// File: rtl/hssi_mb_pkg.sv
// Shared mailbox encodings, register offsets and scheduler state for the
// HSSI mailbox command scheduler.
package hssi_mb_pkg;

    localparam logic [31:0] MB_NOOP   = 32'd0;
    localparam logic [31:0] MB_RD     = 32'd1;
    localparam logic [31:0] MB_WR     = 32'd2;

    localparam logic [31:0] OFF_ADDR  = 32'h4;
    localparam logic [31:0] OFF_RDATA = 32'h8;
    localparam logic [31:0] OFF_WDATA = 32'hC;

    localparam int MB_ACK_BIT = 2;

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        WR_CMD,
        POLL,
        RD_DATA,
        CLR_CMD,
        RESP
    } mb_state_t;

    typedef struct packed {
        logic        wr;
        logic [31:0] wdata;
    } mb_cmd_t;

endpackage

// File: rtl/hssi_mb_rr_arb.sv
// Round-robin arbiter: search starts one past the last granted index and
// wraps; pointer only moves when the grant is taken.
module hssi_mb_rr_arb
    import hssi_mb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               take,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IW-1:0]      gnt_idx,
    output logic               gnt_any
);

    logic [IW-1:0] ptr;

    always_comb begin
        int cand;
        cand    = 0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = (int'(ptr) + i) % NUM_REQ;
            if (!gnt_any && req[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = IW'(cand);
            end
        end
        gnt = gnt_any ? (NUM_REQ'(1) << gnt_idx) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (take) begin
            ptr <= (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + IW'(1);
        end
    end

endmodule

// File: rtl/hssi_mb_cmd_sched.sv
// Arbitrates requester commands onto a single CSR master that drives the
// HSSI mailbox. Define HSSI_MB_TIMEOUT_EN to bound ack polling by POLL_MAX.
module hssi_mb_cmd_sched
    import hssi_mb_pkg::*;
#(
    parameter int          NUM_REQ  = 2,
    parameter logic [31:0] MB_BASE  = 32'h40030,
    parameter int          POLL_MAX = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ-1:0]    req_wr,
    input  logic [NUM_REQ*32-1:0] req_addr,
    input  logic [NUM_REQ*32-1:0] req_wdata,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [NUM_REQ-1:0]    rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic                  csr_wr,
    output logic                  csr_rd,
    output logic [31:0]           csr_addr,
    output logic [31:0]           csr_wdata,
    input  logic                  csr_ack,
    input  logic [31:0]           csr_rdata
);

    localparam int IW = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || POLL_MAX < 1) begin : g_bad_param
        $error("hssi_mb_cmd_sched: NUM_REQ must be 2..8 and POLL_MAX >= 1");
    end

    mb_state_t          state;
    mb_cmd_t            cur;
    logic [IW-1:0]      cur_idx;
    logic [31:0]        rdata_q;
    logic [NUM_REQ-1:0] gnt;
    logic [IW-1:0]      gnt_idx;
    logic               gnt_any;
    logic               take;
    logic [IW+4:0]      sel;

    assign take = (state == IDLE) && gnt_any;
    assign sel  = {gnt_idx, 5'b0};

    hssi_mb_rr_arb #(.NUM_REQ(NUM_REQ), .IW(IW)) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req_valid),
        .take    (take),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

`ifdef HSSI_MB_TIMEOUT_EN
    localparam int PCW = $clog2(POLL_MAX + 1);
    logic [PCW-1:0] poll_cnt;
    logic           err_q;
`else
    assign rsp_err = 1'b0;
`endif

    // Every CSR access is launched from the previous state's ack cycle, so
    // strobe/address/data are registers that stay put until the next ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cur       <= '0;
            cur_idx   <= '0;
            rdata_q   <= '0;
            req_ready <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            csr_wr    <= 1'b0;
            csr_rd    <= 1'b0;
            csr_addr  <= '0;
            csr_wdata <= '0;
`ifdef HSSI_MB_TIMEOUT_EN
            poll_cnt  <= '0;
            err_q     <= 1'b0;
            rsp_err   <= 1'b0;
`endif
        end else begin
            req_ready <= '0;
            rsp_valid <= '0;
            unique case (state)
                IDLE: begin
                    if (gnt_any) begin
                        req_ready <= gnt;
                        cur_idx   <= gnt_idx;
                        cur.wr    <= req_wr[gnt_idx];
                        cur.wdata <= req_wdata[sel +: 32];
                        rdata_q   <= '0;
                        csr_wr    <= 1'b1;
                        csr_addr  <= MB_BASE + OFF_ADDR;
                        csr_wdata <= req_addr[sel +: 32];
                        state     <= WR_ADDR;
`ifdef HSSI_MB_TIMEOUT_EN
                        err_q     <= 1'b0;
`endif
                    end
                end
                WR_ADDR: if (csr_ack) begin
                    if (cur.wr) begin
                        csr_addr  <= MB_BASE + OFF_WDATA;
                        csr_wdata <= cur.wdata;
                        state     <= WR_DATA;
                    end else begin
                        csr_addr  <= MB_BASE;
                        csr_wdata <= MB_RD;
                        state     <= WR_CMD;
                    end
                end
                WR_DATA: if (csr_ack) begin
                    csr_addr  <= MB_BASE;
                    csr_wdata <= MB_WR;
                    state     <= WR_CMD;
                end
                WR_CMD: if (csr_ack) begin
                    csr_wr    <= 1'b0;
                    csr_rd    <= 1'b1;
                    csr_addr  <= MB_BASE;
                    csr_wdata <= '0;
                    state     <= POLL;
`ifdef HSSI_MB_TIMEOUT_EN
                    poll_cnt  <= '0;
`endif
                end
                POLL: if (csr_ack) begin
                    if (csr_rdata[MB_ACK_BIT]) begin
                        if (cur.wr) begin
                            csr_rd    <= 1'b0;
                            csr_wr    <= 1'b1;
                            csr_wdata <= MB_NOOP;
                            state     <= CLR_CMD;
                        end else begin
                            csr_addr  <= MB_BASE + OFF_RDATA;
                            state     <= RD_DATA;
                        end
                    end
`ifdef HSSI_MB_TIMEOUT_EN
                    else if (poll_cnt == PCW'(POLL_MAX - 1)) begin
                        err_q     <= 1'b1;
                        csr_rd    <= 1'b0;
                        csr_wr    <= 1'b1;
                        csr_wdata <= MB_NOOP;
                        state     <= CLR_CMD;
                    end else begin
                        poll_cnt  <= poll_cnt + PCW'(1);
                    end
`endif
                end
                RD_DATA: if (csr_ack) begin
                    rdata_q   <= csr_rdata;
                    csr_rd    <= 1'b0;
                    csr_wr    <= 1'b1;
                    csr_addr  <= MB_BASE;
                    csr_wdata <= MB_NOOP;
                    state     <= CLR_CMD;
                end
                CLR_CMD: if (csr_ack) begin
                    csr_wr    <= 1'b0;
                    csr_addr  <= '0;
                    csr_wdata <= '0;
                    rsp_valid <= NUM_REQ'(1) << cur_idx;
                    rsp_rdata <= rdata_q;
                    state     <= RESP;
`ifdef HSSI_MB_TIMEOUT_EN
                    rsp_err   <= err_q;
`endif
                end
                RESP: begin
                    rsp_rdata <= '0;
                    state     <= IDLE;
`ifdef HSSI_MB_TIMEOUT_EN
                    rsp_err   <= 1'b0;
                    poll_cnt  <= '0;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hssi_mb_cmd_sched.sv
// Scoreboard bench for hssi_mb_cmd_sched: expected grants, CSR accesses and
// responses are queued by the stimulus and popped by independent monitors.
module tb_hssi_mb_cmd_sched;

    localparam int          NR = 2;
    localparam logic [31:0] MB = 32'h40030;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NR-1:0]   req_valid = '0;
    logic [NR-1:0]   req_wr = '0;
    logic [NR*32-1:0] req_addr = '0;
    logic [NR*32-1:0] req_wdata = '0;
    logic [NR-1:0]   req_ready;
    logic [NR-1:0]   rsp_valid;
    logic [31:0]     rsp_rdata;
    logic            rsp_err;
    logic            csr_wr;
    logic            csr_rd;
    logic [31:0]     csr_addr;
    logic [31:0]     csr_wdata;
    logic            csr_ack = 1'b0;
    logic [31:0]     csr_rdata = '0;

    always #5 clk = ~clk;

    hssi_mb_cmd_sched #(.NUM_REQ(NR), .MB_BASE(MB), .POLL_MAX(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .csr_wr    (csr_wr),
        .csr_rd    (csr_rd),
        .csr_addr  (csr_addr),
        .csr_wdata (csr_wdata),
        .csr_ack   (csr_ack),
        .csr_rdata (csr_rdata)
    );

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } csr_t;

    typedef struct {
        int          idx;
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    csr_t exp_csr[$];
    rsp_t exp_rsp[$];
    int   exp_gnt[$];

    int checks = 0;
    int errors = 0;

    int          ack_delay  = 0;
    int          wait_cnt   = 0;
    int          poll_idx   = 0;
    int          poll_ack_n = 1;
    logic [31:0] rd_val     = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // CSR slave with programmable ack latency; also the CSR-side monitor.
    always @(negedge clk) begin : slave
        csr_t        e;
        logic [33:0] cap_ctl;
        logic [31:0] cap_addr;
        if (!rst_n) begin
            csr_ack  = 1'b0;
            wait_cnt = 0;
        end else if (csr_wr || csr_rd) begin
            check("wr_rd_exclusive", 64'(csr_wr & csr_rd), 64'd0);
            if (wait_cnt == 0) begin
                cap_ctl  = {csr_wr, csr_rd, csr_wdata};
                cap_addr = csr_addr;
            end else begin
                check("held_ctl", 64'({csr_wr, csr_rd, csr_wdata}), 64'(cap_ctl));
                check("held_addr", 64'(csr_addr), 64'(cap_addr));
            end
            if (wait_cnt == ack_delay) begin
                csr_ack  = 1'b1;
                wait_cnt = 0;
                if (csr_rd && csr_addr == MB) begin
                    poll_idx++;
                    csr_rdata = (poll_ack_n != 0 && poll_idx >= poll_ack_n) ? 32'h4 : 32'h0;
                end else if (csr_rd && csr_addr == MB + 32'h8) begin
                    csr_rdata = rd_val;
                end else begin
                    csr_rdata = 32'hDEAD_BEEF;
                end
                if (csr_wr && csr_addr == MB && csr_wdata != 0) poll_idx = 0;
                if (exp_csr.size() == 0) begin
                    fail_now($sformatf("csr_unexpected wr=%0b addr=%0h data=%0h", csr_wr, csr_addr, csr_wdata));
                end else begin
                    e = exp_csr.pop_front();
                    check("csr_kind", 64'({csr_wr, csr_rd}), 64'({e.wr, ~e.wr}));
                    check("csr_addr", 64'(csr_addr), 64'(e.addr));
                    if (e.wr) check("csr_wdata", 64'(csr_wdata), 64'(e.data));
                end
            end else begin
                csr_ack = 1'b0;
                wait_cnt++;
            end
        end else begin
            csr_ack  = 1'b0;
            wait_cnt = 0;
        end
    end

    // Grant and response monitor.
    always @(negedge clk) begin : mon
        rsp_t r;
        int   g;
        if (rst_n) begin
            if (req_ready != 0) begin
                if (exp_gnt.size() == 0) fail_now($sformatf("grant_unexpected got %0b", req_ready));
                else begin
                    g = exp_gnt.pop_front();
                    check("grant", 64'(req_ready), 64'(NR'(1) << g));
                end
            end
            if (rsp_valid != 0) begin
                if (exp_rsp.size() == 0) fail_now($sformatf("rsp_unexpected got %0b", rsp_valid));
                else begin
                    r = exp_rsp.pop_front();
                    check("rsp_valid", 64'(rsp_valid), 64'(NR'(1) << r.idx));
                    check("rsp_rdata", 64'(rsp_rdata), 64'(r.rdata));
                    check("rsp_err", 64'(rsp_err), 64'(r.err));
                end
            end
        end
    end

    task automatic push_csr(input logic wr, input logic [31:0] addr, input logic [31:0] data);
        csr_t c;
        c.wr = wr; c.addr = addr; c.data = data;
        exp_csr.push_back(c);
    endtask

    task automatic push_txn(input int idx, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input int npolls,
                            input logic [31:0] rdv, input logic err);
        rsp_t r;
        exp_gnt.push_back(idx);
        push_csr(1'b1, MB + 32'h4, addr);
        if (wr) push_csr(1'b1, MB + 32'hC, wdata);
        push_csr(1'b1, MB, wr ? 32'd2 : 32'd1);
        for (int i = 0; i < npolls; i++) push_csr(1'b0, MB, 32'd0);
        if (!wr && !err) push_csr(1'b0, MB + 32'h8, 32'd0);
        push_csr(1'b1, MB, 32'd0);
        r.idx = idx; r.rdata = (wr || err) ? 32'd0 : rdv; r.err = err;
        exp_rsp.push_back(r);
    endtask

    task automatic drive_req(input int idx, input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
        req_valid[idx]          = 1'b1;
        req_wr[idx]             = wr;
        req_addr[idx*32 +: 32]  = addr;
        req_wdata[idx*32 +: 32] = wdata;
    endtask

    task automatic issue(input int idx, input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
        bit got = 0;
        @(negedge clk);
        drive_req(idx, wr, addr, wdata);
        for (int c = 0; c < 100 && !got; c++) begin
            @(negedge clk);
            if (req_ready[idx]) got = 1;
        end
        req_valid[idx] = 1'b0;
        if (!got) fail_now($sformatf("grant_timeout req %0d", idx));
    endtask

    task automatic drain(input int budget);
        int c = 0;
        while ((exp_rsp.size() != 0 || exp_csr.size() != 0 || exp_gnt.size() != 0) && c < budget) begin
            @(negedge clk);
            c++;
        end
        check("drain_left", 64'(exp_rsp.size() + exp_csr.size() + exp_gnt.size()), 64'd0);
        @(negedge clk);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ctl"}, 64'({req_ready, rsp_valid, rsp_rdata, rsp_err, csr_wr, csr_rd}), 64'd0);
        check({tag, "_bus"}, {csr_addr, csr_wdata}, 64'd0);
    endtask

    initial begin : stim
        int  n;
        bit  hit;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_outputs_zero("idle");

        // write from req0, ack on third poll
        poll_ack_n = 3;
        push_txn(0, 1'b1, 32'h0D, 32'h40, 3, 32'd0, 1'b0);
        issue(0, 1'b1, 32'h0D, 32'h40);
        drain(300);

        // read from req1
        rd_val = 32'h1234; poll_ack_n = 1;
        push_txn(1, 1'b0, 32'h101, 32'd0, 1, 32'h1234, 1'b0);
        issue(1, 1'b0, 32'h101, 32'hFFFF);
        drain(300);

        // both held valid: grants alternate 0,1,0,1
        rd_val = 32'h55AA; poll_ack_n = 2;
        for (int k = 0; k < 2; k++) begin
            push_txn(0, 1'b1, 32'h20, 32'hA5, 2, 32'd0, 1'b0);
            push_txn(1, 1'b0, 32'h24, 32'd0, 2, 32'h55AA, 1'b0);
        end
        @(negedge clk);
        drive_req(0, 1'b1, 32'h20, 32'hA5);
        drive_req(1, 1'b0, 32'h24, 32'h0);
        n = 0;
        for (int c = 0; c < 2000 && n < 4; c++) begin
            @(negedge clk);
            if (req_ready != 0) n++;
        end
        req_valid = '0;
        check("rr_grant_count", 64'(n), 64'd4);
        drain(2000);

`ifdef HSSI_MB_TIMEOUT_EN
        // ack never arrives: exactly four polls then clear with error
        poll_ack_n = 0;
        push_txn(0, 1'b0, 32'h30, 32'd0, 4, 32'd0, 1'b1);
        issue(0, 1'b0, 32'h30, 32'd0);
        drain(500);
`endif

        // reset while polling
        poll_ack_n = 0; poll_idx = 0;
        exp_gnt.push_back(0);
        push_csr(1'b1, MB + 32'h4, 32'h44);
        push_csr(1'b1, MB + 32'hC, 32'h77);
        push_csr(1'b1, MB, 32'd2);
        push_csr(1'b0, MB, 32'd0);
        push_csr(1'b0, MB, 32'd0);
        issue(0, 1'b1, 32'h44, 32'h77);
        hit = 0;
        for (int c = 0; c < 200 && !hit; c++) begin
            @(posedge clk);
            #1;
            if (poll_idx >= 2) hit = 1;
        end
        if (!hit) fail_now("poll_wait_timeout");
        rst_n = 1'b0;
        #1;
        check_outputs_zero("mid_reset");
        check("mid_reset_left", 64'(exp_csr.size() + exp_gnt.size()), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // both valid after reset: pointer restarts at 0
        poll_ack_n = 1;
        push_txn(0, 1'b1, 32'h50, 32'h66, 1, 32'd0, 1'b0);
        @(negedge clk);
        drive_req(0, 1'b1, 32'h50, 32'h66);
        drive_req(1, 1'b0, 32'h54, 32'h0);
        hit = 0;
        for (int c = 0; c < 100 && !hit; c++) begin
            @(negedge clk);
            if (req_ready != 0) hit = 1;
        end
        req_valid = '0;
        if (!hit) fail_now("post_reset_grant_timeout");
        drain(300);

        // slow slave: five wait cycles per access
        ack_delay = 5; poll_ack_n = 2; rd_val = 32'hCAFE;
        push_txn(1, 1'b0, 32'h200, 32'd0, 2, 32'hCAFE, 1'b0);
        issue(1, 1'b0, 32'h200, 32'd0);
        drain(1000);
        ack_delay = 0;

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
